mcu_bus_arbiter: RTL and testbench

Shares the single 16-bit-address/8-bit-data memory bus between three requesters: the dzcpu core, the GPU fetch unit and the OAM DMA engine. One transaction is in flight at a time; the arbiter registers the winning address/data/strobes onto the memory side, waits the memory read latency, and returns read data with a one-cycle ready pulse. It sits between the requesters and the memory/IO decoder.

---
 rtl/mcu_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mcu_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_bus_arbiter.sv
// Three-way memory bus arbiter (CPU / GPU fetch / OAM DMA) with one transaction in flight,
// fixed read latency, CPU starvation guard and a DMA bus lock. All outputs are registered.
module mcu_bus_arbiter #(
    parameter int pMemLatency  = 1,
    parameter int pStarveLimit = 4
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iCpuReq,
    input  logic        iCpuWe,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    output logic [7:0]  oCpuData,
    output logic        oCpuReady,
    input  logic        iGpuReq,
    input  logic [15:0] iGpuAddr,
    output logic [7:0]  oGpuData,
    output logic        oGpuReady,
    input  logic        iDmaReq,
    input  logic        iDmaWe,
    input  logic        iDmaLock,
    input  logic [15:0] iDmaAddr,
    input  logic [7:0]  iDmaData,
    output logic [7:0]  oDmaData,
    output logic        oDmaReady,
    output logic [15:0] oMemAddr,
    output logic [7:0]  oMemData,
    output logic        oMemRe,
    output logic        oMemWe,
    input  logic [7:0]  iMemData,
    output logic [1:0]  oGrant
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT        = 3'(pMemLatency);
    localparam logic [3:0] STARVE_MAX = 4'(pStarveLimit);
    localparam logic [1:0] OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_GPU = 2'd2, OWN_DMA = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  wait_q, wait_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  cpu_data_q, cpu_data_d, gpu_data_q, gpu_data_d, dma_data_q, dma_data_d;
    logic        mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic        cpu_rdy_q, cpu_rdy_d, gpu_rdy_q, gpu_rdy_d, dma_rdy_q, dma_rdy_d;

    logic [1:0]  win;
    logic        win_we, lock_win;
    logic [15:0] win_addr;
    logic [7:0]  win_data;

    // Winner selection: a locked DMA beats everything, a starved CPU beats the fixed order.
    always_comb begin
        lock_win = iDmaReq & iDmaLock;
        win      = OWN_NONE;
        if (lock_win)                                win = OWN_DMA;
        else if (iCpuReq && starve_q == STARVE_MAX)  win = OWN_CPU;
        else if (iDmaReq)                            win = OWN_DMA;
        else if (iGpuReq)                            win = OWN_GPU;
        else if (iCpuReq)                            win = OWN_CPU;

        win_we   = 1'b0;
        win_addr = iCpuAddr;
        win_data = iCpuData;
        case (win)
            OWN_CPU: win_we = iCpuWe;
            OWN_GPU: begin
                win_addr = iGpuAddr;
                win_data = 8'h00;
            end
            OWN_DMA: begin
                win_we   = iDmaWe;
                win_addr = iDmaAddr;
                win_data = iDmaData;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= S_IDLE;
            grant_q    <= OWN_NONE;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            wait_q     <= 3'd0;
            starve_q   <= 4'd0;
            cpu_data_q <= 8'h00;
            gpu_data_q <= 8'h00;
            dma_data_q <= 8'h00;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_rdy_q  <= 1'b0;
            gpu_rdy_q  <= 1'b0;
            dma_rdy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            cpu_data_q <= cpu_data_d;
            gpu_data_q <= gpu_data_d;
            dma_data_q <= dma_data_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            cpu_rdy_q  <= cpu_rdy_d;
            gpu_rdy_q  <= gpu_rdy_d;
            dma_rdy_q  <= dma_rdy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wait_d     = wait_q;
        starve_d   = starve_q;
        cpu_data_d = cpu_data_q;
        gpu_data_d = gpu_data_q;
        dma_data_d = dma_data_q;
        case (state_q)
            S_IDLE: begin
                grant_d = win;
                // Lock-granted DMA cycles do not count toward CPU starvation.
                if (!iCpuReq || win == OWN_CPU)
                    starve_d = 4'd0;
                else if (!lock_win && starve_q < STARVE_MAX)
                    starve_d = starve_q + 4'd1;
                if (win != OWN_NONE) begin
                    state_d = S_ACCESS;
                    addr_d  = win_addr;
                    wdata_d = win_data;
                    we_d    = win_we;
                end
            end
            S_ACCESS: begin
                state_d = S_WAIT;
                wait_d  = LAT;
            end
            S_WAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q == 3'd1) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        case (grant_q)
                            OWN_CPU: cpu_data_d = iMemData;
                            OWN_GPU: gpu_data_d = iMemData;
                            OWN_DMA: dma_data_d = iMemData;
                            default: ;
                        endcase
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                grant_d = OWN_NONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_re_d  = (state_d == S_ACCESS) && !we_d;
        mem_we_d  = (state_d == S_ACCESS) && we_d;
        cpu_rdy_d = (state_d == S_RESP) && (grant_q == OWN_CPU);
        gpu_rdy_d = (state_d == S_RESP) && (grant_q == OWN_GPU);
        dma_rdy_d = (state_d == S_RESP) && (grant_q == OWN_DMA);
    end

    assign oCpuData  = cpu_data_q;
    assign oGpuData  = gpu_data_q;
    assign oDmaData  = dma_data_q;
    assign oCpuReady = cpu_rdy_q;
    assign oGpuReady = gpu_rdy_q;
    assign oDmaReady = dma_rdy_q;
    assign oMemAddr  = addr_q;
    assign oMemData  = wdata_q;
    assign oMemRe    = mem_re_q;
    assign oMemWe    = mem_we_q;
    assign oGrant    = grant_q;
endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// Scoreboard bench for mcu_bus_arbiter: requester processes issue directed transactions,
// expected completions are queued up front and a monitor checks each ready pulse in order.
module tb_mcu_bus_arbiter;
    localparam int L  = 1;
    localparam int SL = 4;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        iCpuReq, iCpuWe, iGpuReq, iDmaReq, iDmaWe, iDmaLock;
    logic [15:0] iCpuAddr, iGpuAddr, iDmaAddr;
    logic [7:0]  iCpuData, iDmaData, iMemData;
    logic [7:0]  oCpuData, oGpuData, oDmaData, oMemData;
    logic        oCpuReady, oGpuReady, oDmaReady, oMemRe, oMemWe;
    logic [15:0] oMemAddr;
    logic [1:0]  oGrant;

    mcu_bus_arbiter #(.pMemLatency(L), .pStarveLimit(SL)) dut (
        .iClock(iClock), .iReset(iReset),
        .iCpuReq(iCpuReq), .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
        .oCpuData(oCpuData), .oCpuReady(oCpuReady),
        .iGpuReq(iGpuReq), .iGpuAddr(iGpuAddr), .oGpuData(oGpuData), .oGpuReady(oGpuReady),
        .iDmaReq(iDmaReq), .iDmaWe(iDmaWe), .iDmaLock(iDmaLock), .iDmaAddr(iDmaAddr),
        .iDmaData(iDmaData), .oDmaData(oDmaData), .oDmaReady(oDmaReady),
        .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemRe(oMemRe), .oMemWe(oMemWe),
        .iMemData(iMemData), .oGrant(oGrant)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic        we;
        logic        lock;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    typedef struct {
        logic [1:0]  owner;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          gap;
    } exp_t;

    req_t cpu_list[$], gpu_list[$], dma_list[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    // Memory returns data only in the cycle exactly L after the read strobe.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        if (a == 16'hC000) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    logic [7:0]  rd_pipe;
    logic [15:0] ad_pipe [0:7];
    always @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rd_pipe <= 8'h00;
            for (int i = 0; i < 8; i++) ad_pipe[i] <= 16'h0000;
        end else begin
            rd_pipe    <= {rd_pipe[6:0], oMemRe};
            ad_pipe[0] <= oMemAddr;
            for (int i = 1; i < 8; i++) ad_pipe[i] <= ad_pipe[i-1];
        end
    end
    assign iMemData = rd_pipe[L-1] ? mem_f(ad_pipe[L-1]) : 8'hEE;

    initial forever begin
        @(posedge iClock);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rdy_of(input logic [1:0] who);
        case (who)
            2'd1:    return oCpuReady;
            2'd2:    return oGpuReady;
            default: return oDmaReady;
        endcase
    endfunction

    task automatic wait_ready(input logic [1:0] who);
        int n = 0;
        do begin
            @(negedge iClock);
            n++;
        end while (!rdy_of(who) && n < 300);
        if (!rdy_of(who)) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL ready_timeout: requester %0d got no ready within 300 cycles", who);
        end
    endtask

    task automatic run_cpu();
        req_t r;
        while (cpu_list.size() > 0) begin
            r = cpu_list.pop_front();
            iCpuReq = 1'b1; iCpuWe = r.we; iCpuAddr = r.addr; iCpuData = r.wdata;
            wait_ready(2'd1);
        end
        iCpuReq = 1'b0; iCpuWe = 1'b0;
    endtask

    task automatic run_gpu();
        req_t r;
        while (gpu_list.size() > 0) begin
            r = gpu_list.pop_front();
            iGpuReq = 1'b1; iGpuAddr = r.addr;
            wait_ready(2'd2);
        end
        iGpuReq = 1'b0;
    endtask

    task automatic run_dma();
        req_t r;
        while (dma_list.size() > 0) begin
            r = dma_list.pop_front();
            iDmaReq = 1'b1; iDmaWe = r.we; iDmaLock = r.lock; iDmaAddr = r.addr; iDmaData = r.wdata;
            wait_ready(2'd3);
        end
        iDmaReq = 1'b0; iDmaWe = 1'b0; iDmaLock = 1'b0;
    endtask

    task automatic add_req(input int who, input logic we, input logic lock,
                           input logic [15:0] addr, input logic [7:0] wd);
        req_t r;
        r.we = we; r.lock = lock; r.addr = addr; r.wdata = wd;
        if (who == 1) cpu_list.push_back(r);
        else if (who == 2) gpu_list.push_back(r);
        else dma_list.push_back(r);
    endtask

    task automatic add_exp(input logic [1:0] owner, input logic we, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] rd, input int gap);
        exp_t e;
        e.owner = owner; e.we = we; e.addr = addr; e.wdata = wd; e.rdata = rd; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: remembers the strobe cycle, then checks each completion against the queue head.
    logic [15:0] acc_addr;
    logic [7:0]  acc_wdata;
    logic        acc_we, prev_rdy;
    logic [1:0]  acc_grant, rdy_owner;
    int          acc_cyc, strobe_cnt, last_rdy_cyc;
    exp_t        e_cur;
    logic [7:0]  own_data;
    initial begin
        strobe_cnt = 0; prev_rdy = 1'b0; last_rdy_cyc = 0; acc_cyc = 0;
        forever begin
            @(negedge iClock);
            if (iReset) begin
                strobe_cnt = 0;
                prev_rdy   = 1'b0;
            end else begin
                if (prev_rdy) check("grant_zero_in_idle", oGrant, 0);
                if (oMemRe || oMemWe) begin
                    strobe_cnt++;
                    acc_addr = oMemAddr; acc_wdata = oMemData; acc_we = oMemWe;
                    acc_grant = oGrant; acc_cyc = cyc;
                    check("one_strobe_only", 32'(oMemRe) + 32'(oMemWe), 1);
                end
                if (oCpuReady || oGpuReady || oDmaReady) begin
                    check("ready_onehot", 32'(oCpuReady) + 32'(oGpuReady) + 32'(oDmaReady), 1);
                    rdy_owner = oDmaReady ? 2'd3 : (oGpuReady ? 2'd2 : 2'd1);
                    own_data  = (rdy_owner == 2'd3) ? oDmaData : ((rdy_owner == 2'd2) ? oGpuData : oCpuData);
                    if (exp_q.size() == 0) begin
                        n_cmp = n_cmp + 1;
                        n_bad = n_bad + 1;
                        $display("FAIL unexpected_ready: owner %0d pulsed with empty scoreboard", rdy_owner);
                    end else begin
                        e_cur = exp_q.pop_front();
                        check("ready_owner", rdy_owner, e_cur.owner);
                        check("grant_at_resp", oGrant, e_cur.owner);
                        check("grant_at_access", acc_grant, e_cur.owner);
                        check("mem_addr", acc_addr, e_cur.addr);
                        check("mem_we", acc_we, e_cur.we);
                        if (e_cur.we) check("mem_wdata", acc_wdata, e_cur.wdata);
                        check("owner_data", own_data, e_cur.rdata);
                        check("strobe_count", strobe_cnt, 1);
                        check("latency", cyc - acc_cyc, L + 1);
                        if (e_cur.gap > 0) check("ready_spacing", cyc - last_rdy_cyc, e_cur.gap);
                    end
                    last_rdy_cyc = cyc;
                    strobe_cnt   = 0;
                end
                prev_rdy = oCpuReady || oGpuReady || oDmaReady;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ord [12];
        int gi, ci;
        iCpuReq = 0; iCpuWe = 0; iCpuAddr = 0; iCpuData = 0;
        iGpuReq = 0; iGpuAddr = 0;
        iDmaReq = 0; iDmaWe = 0; iDmaLock = 0; iDmaAddr = 0; iDmaData = 0;

        // Reset values
        repeat (2) @(posedge iClock);
        #2;
        check("rst_mem_addr", oMemAddr, 16'h0000);
        check("rst_mem_data", oMemData, 8'h00);
        check("rst_mem_re", oMemRe, 0);
        check("rst_mem_we", oMemWe, 0);
        check("rst_grant", oGrant, 0);
        check("rst_cpu_ready", oCpuReady, 0);
        check("rst_gpu_ready", oGpuReady, 0);
        check("rst_dma_ready", oDmaReady, 0);
        check("rst_cpu_data", oCpuData, 8'h00);
        check("rst_gpu_data", oGpuData, 8'h00);
        check("rst_dma_data", oDmaData, 8'h00);
        iReset = 1'b0;
        @(negedge iClock);

        // Single CPU read, then CPU write leaving read data untouched
        add_req(1, 0, 0, 16'hC000, 8'h00);
        add_exp(2'd1, 0, 16'hC000, 8'h00, 8'h5A, 0);
        add_req(1, 1, 0, 16'hFF40, 8'hA5);
        add_exp(2'd1, 1, 16'hFF40, 8'hA5, 8'h5A, 4);
        run_cpu();
        repeat (2) @(negedge iClock);

        // Simultaneous requests: DMA, GPU, CPU, four cycles apart
        add_req(1, 0, 0, 16'hC001, 8'h00);
        add_req(2, 0, 0, 16'h8000, 8'h00);
        add_req(3, 0, 0, 16'hFE00, 8'h00);
        add_exp(2'd3, 0, 16'hFE00, 8'h00, 8'hC2, 0);
        add_exp(2'd2, 0, 16'h8000, 8'h00, 8'hBC, 4);
        add_exp(2'd1, 0, 16'hC001, 8'h00, 8'hFD, 4);
        fork run_cpu(); run_gpu(); run_dma(); join
        repeat (2) @(negedge iClock);

        // Starvation: four GPU grants then one CPU grant, repeated
        for (int i = 0; i < 10; i++) add_req(2, 0, 0, 16'h8010 + 16'(i), 8'h00);
        add_req(1, 0, 0, 16'hC010, 8'h00);
        add_req(1, 0, 0, 16'hC011, 8'h00);
        ord = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2};
        gi = 0; ci = 0;
        for (int k = 0; k < 12; k++) begin
            if (ord[k] == 2'd2) begin
                add_exp(2'd2, 0, 16'h8010 + 16'(gi), 8'h00, mem_f(16'h8010 + 16'(gi)), (k == 0) ? 0 : 4);
                gi++;
            end else begin
                add_exp(2'd1, 0, 16'hC010 + 16'(ci), 8'h00, mem_f(16'hC010 + 16'(ci)), 4);
                ci++;
            end
        end
        fork run_cpu(); run_gpu(); join
        repeat (2) @(negedge iClock);

        // DMA saturates the counter, then holds the bus under lock; CPU wins once the lock drops
        add_req(1, 0, 0, 16'hC030, 8'h00);
        add_req(3, 0, 0, 16'hFE10, 8'h00);
        add_req(3, 0, 0, 16'hFE11, 8'h00);
        add_req(3, 1, 0, 16'hFE12, 8'h77);
        add_req(3, 0, 0, 16'hFE13, 8'h00);
        for (int i = 0; i < 6; i++) add_req(3, 0, 1, 16'hFE20 + 16'(i), 8'h00);
        add_req(3, 0, 0, 16'hFE30, 8'h00);
        add_exp(2'd3, 0, 16'hFE10, 8'h00, mem_f(16'hFE10), 0);
        add_exp(2'd3, 0, 16'hFE11, 8'h00, mem_f(16'hFE11), 4);
        add_exp(2'd3, 1, 16'hFE12, 8'h77, mem_f(16'hFE11), 4);
        add_exp(2'd3, 0, 16'hFE13, 8'h00, mem_f(16'hFE13), 4);
        for (int i = 0; i < 6; i++)
            add_exp(2'd3, 0, 16'hFE20 + 16'(i), 8'h00, mem_f(16'hFE20 + 16'(i)), 4);
        add_exp(2'd1, 0, 16'hC030, 8'h00, mem_f(16'hC030), 4);
        add_exp(2'd3, 0, 16'hFE30, 8'h00, mem_f(16'hFE30), 4);
        fork run_cpu(); run_dma(); join
        repeat (2) @(negedge iClock);

        // Reset during WAIT of a CPU read: immediate abort, then the held request is re-issued
        add_req(1, 0, 0, 16'hC020, 8'h00);
        add_exp(2'd1, 0, 16'hC020, 8'h00, 8'hDC, 0);
        fork
            run_cpu();
            begin : reset_pulse
                int n;
                n = 0;
                do begin
                    @(negedge iClock);
                    n++;
                end while (!oMemRe && n < 50);
                check("abort_read_strobe_seen", oMemRe, 1);
                @(posedge iClock);
                #2 iReset = 1'b1;
                #1;
                check("abort_grant", oGrant, 0);
                check("abort_mem_re", oMemRe, 0);
                check("abort_mem_we", oMemWe, 0);
                check("abort_mem_addr", oMemAddr, 16'h0000);
                check("abort_cpu_ready", oCpuReady, 0);
                check("abort_cpu_data", oCpuData, 8'h00);
                @(posedge iClock);
                #2 iReset = 1'b0;
            end
        join
        repeat (3) @(negedge iClock);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
